// File: rtl/uart_line_monitor.sv
// rtl/uart_line_monitor.sv - multi-channel UART rx conditioner, tx router and line monitor
// Per channel: synchroniser, glitch filter, falling-edge counter, break detector; global tx routing.
module uart_line_monitor #(
    parameter int N_CH         = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_LEN   = 3,
    parameter int BREAK_CYCLES = 1000,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       rx,
    input  logic [1:0]            mode,
    input  logic                  clr_cnt,
    output logic [N_CH-1:0]       tx,
    output logic [N_CH-1:0]       rx_monitor,
    output logic [N_CH-1:0]       tx_monitor,
    output logic [N_CH*CNT_W-1:0] edge_cnt,
    output logic [N_CH-1:0]       break_det
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int BW = $clog2(BREAK_CYCLES + 1);
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
    localparam logic [BW-1:0] B_MAX  = BW'(BREAK_CYCLES);
    localparam logic [BW-1:0] B_LAST = BW'(BREAK_CYCLES - 1);

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_LOOP  = 2'b01;
    localparam logic [1:0] MODE_CROSS = 2'b10;

    logic [N_CH-1:0] rx_filt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam int NXT = (i + 1) % N_CH;

        logic [SYNC_STAGES-1:0] sync;
        logic                   rx_s;
        logic                   filt;
        logic [FW-1:0]          run;
        logic                   take;
        logic                   fall;
        logic [CNT_W-1:0]       ecnt;
        logic [BW-1:0]          bcnt;
        logic                   brk;
        logic                   tx_r;
        logic                   rx_mon_r;
        logic                   tx_mon_r;

        assign rx_s = sync[SYNC_STAGES-1];
        // A new level is accepted on the FILTER_LEN-th consecutive differing sample.
        assign take = (rx_s != filt) && (run == F_LAST);
        assign fall = take && !rx_s;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync <= '1;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], rx[i]};
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                filt <= 1'b1;
                run  <= '0;
                ecnt <= '0;
                bcnt <= '0;
                brk  <= 1'b0;
            end else begin
                if (rx_s == filt) begin
                    run <= '0;
                end else if (take) begin
                    filt <= rx_s;
                    run  <= '0;
                end else begin
                    run <= run + 1'b1;
                end

                if (clr_cnt) begin
                    ecnt <= '0;
                end else if (fall && (ecnt != {CNT_W{1'b1}})) begin
                    ecnt <= ecnt + 1'b1;
                end

                if (filt) begin
                    bcnt <= '0;
                    brk  <= 1'b0;
                end else begin
                    if (bcnt != B_MAX) begin
                        bcnt <= bcnt + 1'b1;
                    end
                    if (bcnt >= B_LAST) begin
                        brk <= 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                tx_r     <= 1'b1;
                rx_mon_r <= 1'b1;
                tx_mon_r <= 1'b1;
            end else begin
                case (mode)
                    MODE_IDLE:  tx_r <= 1'b1;
                    MODE_LOOP:  tx_r <= filt;
                    MODE_CROSS: tx_r <= rx_filt[NXT];
                    default:    tx_r <= 1'b0;
                endcase
                rx_mon_r <= filt;
                tx_mon_r <= tx_r;
            end
        end

        assign rx_filt[i]                 = filt;
        assign tx[i]                      = tx_r;
        assign rx_monitor[i]              = rx_mon_r;
        assign tx_monitor[i]              = tx_mon_r;
        assign edge_cnt[i*CNT_W +: CNT_W] = ecnt;
        assign break_det[i]               = brk;
    end

endmodule

// File: tb/tb_uart_line_monitor.sv
// tb/tb_uart_line_monitor.sv - directed bench for uart_line_monitor
// N_CH=2, SYNC_STAGES=2, FILTER_LEN=3, BREAK_CYCLES=8, CNT_W=4.
module tb_uart_line_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rx;
    logic [1:0] mode;
    logic       clr_cnt;
    logic [1:0] tx;
    logic [1:0] rx_monitor;
    logic [1:0] tx_monitor;
    logic [7:0] edge_cnt;
    logic [1:0] break_det;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] rx;
        logic [1:0] mode;
        logic [1:0] exp_tx;
    } vec_t;

    vec_t tbl[8];

    uart_line_monitor #(
        .N_CH(2), .SYNC_STAGES(2), .FILTER_LEN(3), .BREAK_CYCLES(8), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .mode(mode), .clr_cnt(clr_cnt),
        .tx(tx), .rx_monitor(rx_monitor), .tx_monitor(tx_monitor),
        .edge_cnt(edge_cnt), .break_det(break_det)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic settle();
        rx = 2'b11;
        tick(10);
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
    endtask

    initial begin
        tbl[0] = '{rx: 2'b11, mode: 2'b00, exp_tx: 2'b11};
        tbl[1] = '{rx: 2'b10, mode: 2'b01, exp_tx: 2'b10};
        tbl[2] = '{rx: 2'b01, mode: 2'b01, exp_tx: 2'b01};
        tbl[3] = '{rx: 2'b01, mode: 2'b10, exp_tx: 2'b10};
        tbl[4] = '{rx: 2'b10, mode: 2'b10, exp_tx: 2'b01};
        tbl[5] = '{rx: 2'b11, mode: 2'b11, exp_tx: 2'b00};
        tbl[6] = '{rx: 2'b00, mode: 2'b00, exp_tx: 2'b11};
        tbl[7] = '{rx: 2'b00, mode: 2'b01, exp_tx: 2'b00};

        rst = 1'b1; rx = 2'b00; mode = 2'b00; clr_cnt = 1'b0;
        tick(3);
        chk("rst_tx", tx, 2'b11);
        chk("rst_rx_mon", rx_monitor, 2'b11);
        chk("rst_tx_mon", tx_monitor, 2'b11);
        chk("rst_edge_cnt", edge_cnt, 8'h00);
        chk("rst_break", break_det, 2'b00);
        rst = 1'b0;
        tick(4);
        chk("post_rst_cnt_e4", edge_cnt, 8'h00);
        chk("post_rst_mon_e4", rx_monitor, 2'b11);
        tick(1);
        chk("post_rst_cnt_e5", edge_cnt, 8'h11);
        tick(1);
        chk("post_rst_mon_e6", rx_monitor, 2'b00);

        // Glitch rejection and loopback latency on channel 0
        mode = 2'b01;
        settle();
        rx = 2'b10;
        tick(2);
        rx = 2'b11;
        tick(10);
        chk("glitch_rx_mon", rx_monitor, 2'b11);
        chk("glitch_tx", tx, 2'b11);
        chk("glitch_cnt", edge_cnt, 8'h00);
        rx = 2'b10;
        tick(3);
        rx = 2'b11;
        tick(2);
        chk("loop_tx_e5", tx, 2'b11);
        tick(1);
        chk("loop_tx_e6", tx, 2'b10);
        chk("loop_cnt", edge_cnt, 8'h01);
        tick(10);
        chk("loop_tx_back", tx, 2'b11);
        chk("loop_cnt_hold", edge_cnt, 8'h01);

        // Mode switches take effect on the next edge
        rx = 2'b01; mode = 2'b10;
        tick(8);
        chk("cross_tx", tx, 2'b10);
        mode = 2'b11;
        tick(1);
        chk("force_brk_tx", tx, 2'b00);
        mode = 2'b00;
        tick(1);
        chk("idle_tx", tx, 2'b11);
        chk("idle_tx_mon_lag", tx_monitor, 2'b00);
        tick(1);
        chk("idle_tx_mon", tx_monitor, 2'b11);

        for (int i = 0; i < 8; i++) begin
            rx = tbl[i].rx; mode = tbl[i].mode;
            tick(10);
            chk($sformatf("tbl%0d_rx_mon", i), rx_monitor, tbl[i].rx);
            chk($sformatf("tbl%0d_tx", i), tx, tbl[i].exp_tx);
            chk($sformatf("tbl%0d_tx_mon", i), tx_monitor, tbl[i].exp_tx);
        end

        // Edge counter saturation and clear priority on channel 1
        mode = 2'b01;
        settle();
        for (int p = 0; p < 14; p++) begin
            rx = 2'b01; tick(4);
            rx = 2'b11; tick(4);
        end
        tick(10);
        chk("cnt14", edge_cnt, 8'he0);
        for (int p = 0; p < 6; p++) begin
            rx = 2'b01; tick(4);
            rx = 2'b11; tick(4);
        end
        tick(10);
        chk("cnt_sat", edge_cnt, 8'hf0);
        rx = 2'b01;
        tick(4);
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
        chk("clr_vs_edge", edge_cnt, 8'h00);
        rx = 2'b11;
        tick(10);
        chk("clr_after_rise", edge_cnt, 8'h00);

        // Break detector on channel 0: 7 low cycles never break, 12 low cycles do
        settle();
        rx = 2'b10;
        for (int k = 1; k <= 20; k++) begin
            if (k == 8) rx = 2'b11;
            tick(1);
            chk($sformatf("nobrk_k%0d", k), break_det, 2'b00);
        end
        chk("nobrk_cnt", edge_cnt, 8'h01);
        rx = 2'b10;
        for (int k = 1; k <= 25; k++) begin
            tick(1);
            if (k == 12) rx = 2'b11;
            chk($sformatf("brk_k%0d", k), break_det, (k >= 13 && k <= 17) ? 2'b01 : 2'b00);
        end
        chk("brk_cnt", edge_cnt, 8'h02);

        // Reset in the middle of a break
        settle();
        for (int p = 0; p < 4; p++) begin
            rx = 2'b10; tick(4);
            rx = 2'b11; tick(4);
        end
        rx = 2'b10;
        tick(15);
        chk("pre_rst_brk", break_det, 2'b01);
        chk("pre_rst_cnt", edge_cnt, 8'h05);
        chk("pre_rst_tx", tx, 2'b10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_brk", break_det, 2'b00);
        chk("mid_rst_cnt", edge_cnt, 8'h00);
        chk("mid_rst_tx", tx, 2'b11);
        chk("mid_rst_rx_mon", rx_monitor, 2'b11);
        chk("mid_rst_tx_mon", tx_monitor, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
